matmul_stream_core: RTL and testbench

Parametrised successor to the fixed-size matrix multiplier core. It accepts two DIM×DIM matrices as a row-major element stream (A first, then B) over a valid/ready handshake. It computes C = A·B with a single time-shared MAC and streams C out row-major over a second valid/ready handshake. It sits between the serial front-end (UART RX/TX, bit_period config) and the chip top. It adds selectable signed/unsigned arithmetic, output backpressure and a synchronous abort.

---
 rtl/matmul_pkg.sv | 30 +++
 rtl/matmul_mac.sv | 32 +++
 rtl/matmul_stream_core.sv | 155 +++++++++++++++
 tb/tb_matmul_stream_core.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the streaming matrix multiplier.
// Widths derive from DIM/DATA_W so every instance sizes itself.
package matmul_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMPUTE,
    S_EMIT
  } state_e;

  localparam int DIM_DEF    = 2;
  localparam int DATA_W_DEF = 8;

  function automatic int acc_width(int dim, int data_w);
    return 2 * data_w + $clog2(dim);
  endfunction

  function automatic int cnt_width(int dim);
    return $clog2(2 * dim * dim);
  endfunction

  // A DIM of 1 still needs a one-bit index register.
  function automatic int idx_width(int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  localparam int LOAD_CNT_W_DEF = cnt_width(DIM_DEF);
  localparam int IDX_W_DEF      = idx_width(DIM_DEF);

endpackage

// File: rtl/matmul_mac.sv
// Combinational multiply-add: sum = acc + a*b, operands signed or unsigned.
// The product always fits in 2*DATA_W bits, so it is formed there then extended.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = acc_width(DIM_DEF, DATA_W_DEF)
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [ACC_W-1:0]  acc_i,
  input  logic              signed_i,
  output logic [ACC_W-1:0]  sum_o
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;
  logic signed [PW-1:0] prod;
  logic [ACC_W-1:0]     prod_x;

  always_comb begin
    a_x = signed_i ? PW'($signed(a_i)) : PW'(a_i);
    b_x = signed_i ? PW'($signed(b_i)) : PW'(b_i);
    prod = a_x * b_x;
    prod_x = signed_i ? ACC_W'(prod)
                      : ACC_W'($unsigned(prod));
    sum_o = acc_i + prod_x;
  end

endmodule

// File: rtl/matmul_stream_core.sv
// Streams in A then B row-major, computes C = A*B on one shared MAC,
// and streams C out row-major under valid/ready with abort support.
module matmul_stream_core
  import matmul_pkg::*;
#(
  parameter int DIM    = DIM_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = acc_width(DIM, DATA_W)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              signed_mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int N  = DIM * DIM;
  localparam int LW = cnt_width(DIM);
  localparam int IW = idx_width(DIM);

  localparam logic [LW-1:0] LAST_LD = LW'(2 * N - 1);
  localparam logic [IW-1:0] LAST_IX = IW'(DIM - 1);

  state_e            state_q;
  logic [LW-1:0]     load_cnt_q;
  logic [IW-1:0]     i_q;
  logic [IW-1:0]     j_q;
  logic [IW-1:0]     k_q;
  logic [ACC_W-1:0]  acc_q;
  logic              signed_q;
  logic              out_valid_q;

  logic [DATA_W-1:0] mem_q [2*N];

  logic [LW-1:0]     a_addr;
  logic [LW-1:0]     b_addr;
  logic [ACC_W-1:0]  mac_sum;
  logic              in_hs;
  logic              out_hs;
  logic              last_ij;

  assign a_addr = LW'(i_q) * LW'(DIM) + LW'(k_q);
  assign b_addr = LW'(N) + LW'(k_q) * LW'(DIM)
                + LW'(j_q);

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_LOAD);
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? acc_q : '0;

  assign in_hs   = in_valid & in_ready;
  assign out_hs  = out_valid_q & out_ready;
  assign last_ij = (i_q == LAST_IX) && (j_q == LAST_IX);
  // An abort in the same cycle suppresses the completion pulse.
  assign done    = out_hs & last_ij & ~clear;

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a_i      (mem_q[a_addr]),
    .b_i      (mem_q[b_addr]),
    .acc_i    (acc_q),
    .signed_i (signed_q),
    .sum_o    (mac_sum)
  );

  always_ff @(posedge clk) begin
    if (in_hs && !clear) begin
      mem_q[load_cnt_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_LOAD;
      load_cnt_q  <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      signed_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state_q     <= S_LOAD;
      load_cnt_q  <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (in_hs) begin
            if (load_cnt_q == '0) begin
              signed_q <= signed_mode;
            end
            if (load_cnt_q == LAST_LD) begin
              state_q    <= S_COMPUTE;
              load_cnt_q <= '0;
              i_q        <= '0;
              j_q        <= '0;
              k_q        <= '0;
              acc_q      <= '0;
            end else begin
              load_cnt_q <= load_cnt_q + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          acc_q <= mac_sum;
          if (k_q == LAST_IX) begin
            state_q     <= S_EMIT;
            out_valid_q <= 1'b1;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_EMIT: begin
          if (out_hs) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            k_q         <= '0;
            if (last_ij) begin
              state_q    <= S_LOAD;
              load_cnt_q <= '0;
              i_q        <= '0;
              j_q        <= '0;
            end else begin
              state_q <= S_COMPUTE;
              if (j_q == LAST_IX) begin
                j_q <= '0;
                i_q <= i_q + 1'b1;
              end else begin
                j_q <= j_q + 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_stream_core.sv
// Randomised self-checking bench for matmul_stream_core (DIM=2, DATA_W=8).
// Expected C comes from plain integer matrix arithmetic on the stimulus.
module tb_matmul_stream_core;

  localparam int DIM    = 2;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 17;
  localparam int N      = DIM * DIM;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              clear;
  logic              signed_mode;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic              out_ready;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] stim [2*N];
  logic [ACC_W-1:0]  exp_c [N];

  always #5 clk = ~clk;

  matmul_stream_core #(
    .DIM    (DIM),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (clear),
    .signed_mode (signed_mode),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  function automatic longint elem(input logic [DATA_W-1:0] x,
                                  input logic sm);
    return sm ? longint'($signed(x)) : longint'(x);
  endfunction

  task automatic build_ref(input logic sm);
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        longint s;
        s = 0;
        for (int k = 0; k < DIM; k++) begin
          s += elem(stim[r*DIM+k], sm) * elem(stim[N+k*DIM+c], sm);
        end
        exp_c[r*DIM+c] = s[ACC_W-1:0];
      end
    end
  endtask

  task automatic set_basic();
    for (int e = 0; e < N; e++) begin
      stim[e]   = 8'(e + 1);
      stim[N+e] = 8'(e + 5);
    end
  endtask

  // Mode is flipped after the first element to confirm it is latched once.
  task automatic load_all(input logic sm, input bit gaps);
    for (int e = 0; e < 2*N; e++) begin
      @(negedge clk);
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid    = 1'b1;
      in_data     = stim[e];
      signed_mode = (e == 0) ? sm : ~sm;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain(input int n, input int stall_idx,
                       input int stall_n, input bit noise);
    int got;
    int cyc;
    int last;
    got  = 0;
    cyc  = 0;
    last = -1;
    out_ready = 1'b1;
    while (got < n && cyc < 400) begin
      in_valid = noise && (got < N - 1);
      in_data  = 8'hEE;
      if (out_valid === 1'b1) begin
        if (got == stall_idx && stall_n > 0) begin
          out_ready = 1'b0;
          for (int s = 0; s < stall_n; s++) begin
            @(negedge clk);
            cyc++;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_c[got]
                || in_ready !== 1'b0 || done !== 1'b0) begin
              n_fail++;
              $display("FAIL stall[%0d]: valid=%b data=%h rdy=%b done=%b want 1 %h 0 0",
                       got, out_valid, out_data, in_ready, done,
                       exp_c[got]);
            end
          end
          out_ready = 1'b1;
        end else if (last >= 0) begin
          n_checks++;
          if (cyc - last != DIM + 1) begin
            n_fail++;
            $display("FAIL throughput[%0d]: got %0d cycles want %0d",
                     got, cyc - last, DIM + 1);
          end
        end
        n_checks++;
        if (out_data !== exp_c[got]) begin
          n_fail++;
          $display("FAIL c[%0d]: got %h want %h",
                   got, out_data, exp_c[got]);
        end
        n_checks++;
        if (done !== (got == N - 1)) begin
          n_fail++;
          $display("FAIL done[%0d]: got %b want %b",
                   got, done, got == N - 1);
        end
        last = cyc;
        got++;
      end else begin
        n_checks++;
        if (out_data !== '0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_out: data=%h done=%b want 0 0",
                   out_data, done);
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (got < n) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d elements want %0d", got, n);
    end
  endtask

  task automatic wait_valid(input string tag);
    int t;
    t = 0;
    while (out_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: out_valid=%b want 1", tag, out_valid);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    clear = 1'b0;
    signed_mode = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0
        || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: v=%b d=%h b=%b dn=%b want 0 0 0 0",
               out_valid, out_data, busy, done);
    end
    n_rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rel: rdy=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    set_basic();
    build_ref(1'b0);
    load_all(1'b0, 1'b0);
    for (int e = 0; e < DIM + 1; e++) begin
      n_checks++;
      if (out_valid !== (e == DIM)) begin
        n_fail++;
        $display("FAIL latency[%0d]: out_valid=%b want %b",
                 e, out_valid, e == DIM);
      end
      n_checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy[%0d]: busy=%b rdy=%b want 1 0",
                 e, busy, in_ready);
      end
      if (e < DIM) @(negedge clk);
    end
    drain(N, -1, 0, 1'b1);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: rdy=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_signed();
    stim = '{8'hFF, 8'h02, 8'h03, 8'hFC, 8'h01, 8'h00, 8'h00, 8'h01};
    build_ref(1'b1);
    load_all(1'b1, 1'b0);
    drain(N, -1, 0, 1'b0);
    build_ref(1'b0);
    load_all(1'b0, 1'b0);
    drain(N, -1, 0, 1'b0);
  endtask

  task automatic test_max();
    for (int e = 0; e < 2*N; e++) stim[e] = 8'hFF;
    build_ref(1'b0);
    load_all(1'b0, 1'b0);
    drain(N, -1, 0, 1'b0);
    for (int e = 0; e < 2*N; e++) stim[e] = 8'h80;
    build_ref(1'b1);
    load_all(1'b1, 1'b0);
    drain(N, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    set_basic();
    build_ref(1'b0);
    load_all(1'b0, 1'b0);
    drain(N, 1, 5, 1'b0);
  endtask

  task automatic test_abort();
    set_basic();
    build_ref(1'b0);
    load_all(1'b0, 1'b0);
    drain(2, -1, 0, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: v=%b rdy=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_idle: v=%b done=%b want 0 0",
                 out_valid, done);
      end
    end
    load_all(1'b0, 1'b0);
    drain(N - 1, -1, 0, 1'b0);
    wait_valid("abort_last_wait");
    out_ready = 1'b1;
    clear = 1'b1;
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done: got %b want 0", done);
    end
    @(negedge clk);
    clear = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_emit: v=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
    load_all(1'b0, 1'b0);
    drain(N, -1, 0, 1'b0);
  endtask

  task automatic test_reset_midload();
    set_basic();
    build_ref(1'b0);
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = stim[e];
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_load: v=%b d=%h busy=%b want 0 0 0",
               out_valid, out_data, busy);
    end
    @(negedge clk);
    n_rst = 1'b1;
    load_all(1'b0, 1'b0);
    wait_valid("rst_emit_wait");
    n_rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_emit: v=%b d=%h busy=%b want 0 0 0",
               out_valid, out_data, busy);
    end
    @(negedge clk);
    n_rst = 1'b1;
    load_all(1'b0, 1'b0);
    drain(N, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic sm;
      sm = 1'($urandom_range(0, 1));
      for (int e = 0; e < 2*N; e++) stim[e] = 8'($urandom);
      build_ref(sm);
      load_all(sm, 1'b1);
      drain(N, $urandom_range(0, N - 1), $urandom_range(0, 3),
            1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_max();
    test_backpressure();
    test_abort();
    test_reset_midload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
